// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: assembles little-endian 32-bit words from a shared
// byte-wide, one-cycle-latency memory port and buffers DEPTH words with their PCs.
module inst_fetch_queue #(
  parameter int unsigned       ADDR_W   = 17,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              mem_grant,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_a,
  input  logic [7:0]        mem_din,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  localparam int unsigned       PW         = $clog2(DEPTH);
  localparam int unsigned       CW         = $clog2(DEPTH + 1);
  localparam int unsigned       OW         = CW + 1;
  localparam logic [31:0]       NOP        = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] RESET_PC_W = RESET_PC & ALIGN_MASK;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]        issue_idx_q, issue_idx_d;
  logic [1:0]        cap_idx_q, cap_idx_d;
  logic              resp_pend_q, resp_pend_d;
  logic [31:0]       asm_word_q, asm_word_d;
  logic [31:0]       word_q [DEPTH];
  logic [31:0]       word_d [DEPTH];
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [ADDR_W-1:0] pc_d [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic              flush, inflight, issue_ok, issue_fire, capture, push, pop;
  logic [OW-1:0]     occupancy;
  logic [ADDR_W-1:0] flush_pc;

  always_comb begin
    flush      = rst || redirect;
    flush_pc   = rst ? RESET_PC_W : (redirect_pc & ALIGN_MASK);
    // A word whose last byte is still in flight already owns a queue slot.
    inflight   = resp_pend_q && (cap_idx_q == 2'd3);
    occupancy  = OW'(count_q) + OW'(inflight);
    issue_ok   = !flush && ((issue_idx_q != 2'd0) || (occupancy < OW'(DEPTH)));
    issue_fire = issue_ok && mem_grant;
    mem_rd     = issue_ok;
    mem_a      = issue_ok ? (fetch_pc_q + ADDR_W'(issue_idx_q)) : '0;
    inst_valid = (count_q != '0);
    inst       = inst_valid ? word_q[head_q] : NOP;
    inst_pc    = inst_valid ? pc_q[head_q] : '0;
    capture    = resp_pend_q && !flush;
    push       = capture && (cap_idx_q == 2'd3);
    pop        = inst_valid && inst_ready && !flush;
  end

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    issue_idx_d = issue_idx_q;
    cap_idx_d   = cap_idx_q;
    resp_pend_d = resp_pend_q;
    asm_word_d  = asm_word_q;
    word_d      = word_q;
    pc_d        = pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    if (flush) begin
      fetch_pc_d  = flush_pc;
      issue_idx_d = '0;
      cap_idx_d   = '0;
      resp_pend_d = 1'b0;
      asm_word_d  = '0;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
    end else begin
      resp_pend_d = issue_fire;
      if (issue_fire) begin
        cap_idx_d   = issue_idx_q;
        issue_idx_d = issue_idx_q + 2'd1;
        if (issue_idx_q == 2'd3) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
      if (capture) asm_word_d[{cap_idx_q, 3'b000} +: 8] = mem_din;
      if (push) begin
        word_d[tail_q] = {mem_din, asm_word_q[23:0]};
        // fetch_pc moved past this word when its last byte was issued
        pc_d[tail_q]   = fetch_pc_q - ADDR_W'(4);
        tail_d         = tail_q + PW'(1);
      end
      if (pop) head_d = head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC_W;
      issue_idx_q <= '0;
      cap_idx_q   <= '0;
      resp_pend_q <= 1'b0;
      asm_word_q  <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      issue_idx_q <= issue_idx_d;
      cap_idx_q   <= cap_idx_d;
      resp_pend_q <= resp_pend_d;
      asm_word_q  <= asm_word_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
    word_q <= word_d;
    pc_q   <= pc_d;
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed table and corner sequences plus random
// traffic, all checked against a transaction-level queue model.
module tb_inst_fetch_queue;

  localparam int unsigned       ADDR_W   = 17;
  localparam int unsigned       DEPTH    = 4;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;
  localparam logic [31:0]       NOP      = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst, redirect, mem_grant, inst_ready;
  logic [ADDR_W-1:0] redirect_pc;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_a;
  logic [7:0]        mem_din = 8'h00;
  logic              inst_valid;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_pc;

  inst_fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_grant(mem_grant), .mem_rd(mem_rd), .mem_a(mem_a), .mem_din(mem_din),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte memory with one-cycle read latency; garbage when nothing is due.
  logic [7:0]        mem [2**ADDR_W];
  logic              resp_due = 1'b0;
  logic [ADDR_W-1:0] resp_addr = '0;
  logic [7:0]        next_din;

  always @(negedge clk) begin
    resp_due  = mem_rd && mem_grant;
    resp_addr = mem_a;
  end
  always @(posedge clk) begin
    next_din = resp_due ? mem[resp_addr] : 8'($urandom);
    #1 mem_din = next_din;
  end

  // Reference model: next byte address, pending completed word, queue of words.
  typedef struct { logic [31:0] w; logic [ADDR_W-1:0] pc; } ent_t;
  ent_t              mq[$];
  logic [ADDR_W-1:0] m_addr;
  int                m_pend = 0;
  logic [ADDR_W-1:0] m_pend_pc;
  bit                chk_en = 1'b0;
  bit                e_rd, m_issue;

  function automatic logic [31:0] word_at(input logic [ADDR_W-1:0] a);
    return {mem[a + ADDR_W'(3)], mem[a + ADDR_W'(2)], mem[a + ADDR_W'(1)], mem[a]};
  endfunction

  function automatic bit model_rd();
    return !rst && !redirect && ((m_addr % 4 != 0) || (mq.size() + m_pend < DEPTH));
  endfunction

  always @(posedge clk) begin
    if (rst || redirect) begin
      mq.delete();
      m_addr = rst ? RESET_PC : (redirect_pc & ~ADDR_W'(3));
      m_pend = 0;
    end else begin
      m_issue = model_rd() && mem_grant;
      if (mq.size() != 0 && inst_ready) void'(mq.pop_front());
      if (m_pend != 0) mq.push_back('{word_at(m_pend_pc), m_pend_pc});
      m_pend = 0;
      if (m_issue) begin
        if (m_addr % 4 == 3) begin
          m_pend    = 1;
          m_pend_pc = m_addr - ADDR_W'(3);
        end
        m_addr = m_addr + ADDR_W'(1);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      e_rd = model_rd();
      check("mdl_mem_rd", 32'(mem_rd), 32'(e_rd));
      if (e_rd) check("mdl_mem_a", 32'(mem_a), 32'(m_addr));
      check("mdl_valid", 32'(inst_valid), 32'(mq.size() != 0));
      check("mdl_inst", inst, (mq.size() != 0) ? mq[0].w : NOP);
      check("mdl_pc", 32'(inst_pc), (mq.size() != 0) ? 32'(mq[0].pc) : 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic negc();
    @(negedge clk);
  endtask

  task automatic do_redirect(input logic [ADDR_W-1:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    step();
    redirect = 1'b0;
  endtask

  typedef struct {
    logic grant; logic ready; logic rd; logic [31:0] a;
    logic valid; logic [31:0] ins; logic [31:0] pc;
  } vec_t;
  vec_t tbl [10];

  int                grants, pops;
  logic              prev_held;
  logic [ADDR_W-1:0] prev_a;

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; mem_grant = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
    mem[4] = 8'h93; mem[5] = 8'h00; mem[6] = 8'h10; mem[7] = 8'h00;

    // Cycles r+1 .. r+10 after reset release, continuous grant and ready.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 32'd0, 1'b0, NOP, 32'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'd1, 1'b0, NOP, 32'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'd2, 1'b0, NOP, 32'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'd3, 1'b0, NOP, 32'd0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 32'd4, 1'b0, NOP, 32'd0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 32'd5, 1'b1, 32'h0000_0013, 32'd0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 32'd6, 1'b0, NOP, 32'd0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 32'd7, 1'b0, NOP, 32'd0};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 32'd8, 1'b0, NOP, 32'd0};
    tbl[9] = '{1'b1, 1'b1, 1'b1, 32'd9, 1'b1, 32'h0010_0093, 32'd4};

    step();
    chk_en = 1'b1;
    negc();
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_a", 32'(mem_a), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, NOP);
    check("rst_pc", 32'(inst_pc), 32'd0);
    step();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      mem_grant  = tbl[i].grant;
      inst_ready = tbl[i].ready;
      negc();
      check($sformatf("tbl%0d_rd", i), 32'(mem_rd), 32'(tbl[i].rd));
      if (tbl[i].rd) check($sformatf("tbl%0d_a", i), 32'(mem_a), tbl[i].a);
      check($sformatf("tbl%0d_valid", i), 32'(inst_valid), 32'(tbl[i].valid));
      check($sformatf("tbl%0d_inst", i), inst, tbl[i].ins);
      check($sformatf("tbl%0d_pc", i), 32'(inst_pc), tbl[i].pc);
      step();
    end

    // Back-pressure: queue fills after exactly DEPTH*4 byte reads.
    inst_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = '0;
    negc();
    check("redir_no_rd", 32'(mem_rd), 32'd0);
    step();
    redirect = 1'b0;
    grants = 0;
    for (int i = 0; i < 30; i++) begin
      negc();
      if (mem_rd && mem_grant) grants++;
      step();
    end
    check("full_reads", 32'(grants), 32'(DEPTH * 4));
    negc();
    check("full_stall", 32'(mem_rd), 32'd0);
    step();
    inst_ready = 1'b1;
    negc();
    check("full_pop_valid", 32'(inst_valid), 32'd1);
    check("full_pop_pc", 32'(inst_pc), 32'd0);
    step();
    inst_ready = 1'b0;
    negc();
    check("resume_rd", 32'(mem_rd), 32'd1);
    check("resume_a", 32'(mem_a), 32'h10);
    step();

    // Grant toggling mid-word: address holds while ungranted.
    inst_ready = 1'b1;
    do_redirect(17'h40);
    prev_held = 1'b0;
    prev_a    = '0;
    for (int i = 0; i < 36; i++) begin
      mem_grant = (i % 3 == 0);
      negc();
      if (prev_held) check("hold_a", 32'(mem_a), 32'(prev_a));
      prev_held = mem_rd && !mem_grant;
      prev_a    = mem_a;
      step();
    end
    mem_grant = 1'b1;

    // Redirect with byte 2 outstanding and two words queued.
    inst_ready = 1'b0;
    do_redirect(17'h200);
    for (int i = 0; i < 11; i++) step();
    redirect    = 1'b1;
    redirect_pc = 17'h102;
    negc();
    check("rdr_before_valid", 32'(inst_valid), 32'd1);
    check("rdr_before_pc", 32'(inst_pc), 32'h200);
    check("rdr_cycle_rd", 32'(mem_rd), 32'd0);
    step();
    redirect = 1'b0;
    negc();
    check("rdr_flush_valid", 32'(inst_valid), 32'd0);
    check("rdr_new_rd", 32'(mem_rd), 32'd1);
    check("rdr_new_a", 32'(mem_a), 32'h100);
    for (int i = 0; i < 4; i++) step();
    negc();
    check("rdr_t5_valid", 32'(inst_valid), 32'd0);
    step();
    negc();
    check("rdr_t6_valid", 32'(inst_valid), 32'd1);
    check("rdr_t6_pc", 32'(inst_pc), 32'h100);
    check("rdr_t6_inst", inst, word_at(17'h100));
    step();

    // Full queue, pop every 5 cycles: pops coincide with pushes at DEPTH-1.
    do_redirect(17'h300);
    for (int i = 0; i < 20; i++) step();
    pops = 0;
    for (int i = 0; i < 3 * DEPTH * 5; i++) begin
      inst_ready = (i % 5 == 0);
      negc();
      if (inst_ready && inst_valid) begin
        check("wrap_pc", 32'(inst_pc), 32'h300 + 32'(4 * pops));
        pops++;
      end
      step();
    end
    inst_ready = 1'b0;
    check("wrap_pops", 32'(pops), 32'(3 * DEPTH));

    // One-cycle reset in the middle of a word.
    inst_ready = 1'b1;
    do_redirect(17'h400);
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1;
    negc();
    check("mrst_rd", 32'(mem_rd), 32'd0);
    step();
    rst = 1'b0;
    negc();
    check("mrst_valid", 32'(inst_valid), 32'd0);
    check("mrst_inst", inst, NOP);
    check("mrst_pc", 32'(inst_pc), 32'd0);
    check("mrst_rd_after", 32'(mem_rd), 32'd1);
    check("mrst_a_after", 32'(mem_a), 32'(RESET_PC));
    for (int i = 0; i < 8; i++) step();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      mem_grant   = ($urandom_range(0, 9) < 7);
      inst_ready  = ($urandom_range(0, 1) == 1);
      redirect    = ($urandom_range(0, 49) == 0);
      redirect_pc = ADDR_W'($urandom_range(0, 1023));
      rst         = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; redirect = 1'b0;
    step();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
